// File: rtl/dct_stream_checker_if.sv
// Bundle of the checker's run-control, DUT stream, expected-memory and result signals.
interface dct_stream_checker_if #(
  parameter int LANES = 8,
  parameter int BW    = 12,
  parameter int AW    = 15
);
  logic                  start;
  logic                  mode;
  logic [15:0]           skip_beats;
  logic                  dut_valid;
  logic [LANES*BW-1:0]   dut_data;
  logic                  exp_rd;
  logic [AW-1:0]         exp_addr;
  logic [LANES*BW-1:0]   exp_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [31:0]           err_count;
  logic                  first_err_valid;
  logic [AW-1:0]         first_err_idx;
  logic [LANES-1:0]      first_err_lanes;

  // Checker side: consumes the stream and memory data, reports results.
  modport slave (
    input  start, mode, skip_beats, dut_valid, dut_data, exp_data,
    output exp_rd, exp_addr, busy, done, pass, err_count,
           first_err_valid, first_err_idx, first_err_lanes
  );

  // Driver side: runs the checker and serves the expected memory.
  modport master (
    output start, mode, skip_beats, dut_valid, dut_data, exp_data,
    input  exp_rd, exp_addr, busy, done, pass, err_count,
           first_err_valid, first_err_idx, first_err_lanes
  );
endinterface

// File: rtl/dct_stream_checker.sv
// Golden-vector checker for the 2D-DCT datapath: compares each accepted
// DUT beat against an expected beat read from a 1-cycle-latency memory,
// counts mismatching beats and captures the first mismatch of the run.
module dct_stream_checker #(
  parameter int LANES   = 8,
  parameter int BW      = 12,
  parameter int AW      = 15,
  parameter int NUM_VEC = 32768,
  parameter int TOL     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  dct_stream_checker_if.slave   bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VEC - 1);
  localparam logic [BW:0]   TOL_W    = (BW + 1)'(TOL);

  typedef enum logic [2:0] {IDLE, SKIP, CHECK, DRAIN, DONE} state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [15:0]           r_skip;
  logic [AW-1:0]         r_idx;
  logic                  r_cmpValid;
  logic [AW-1:0]         r_cmpIdx;
  logic [LANES*BW-1:0]   r_dut;
  logic                  r_done;
  logic [31:0]           r_errCount;
  logic                  r_firstValid;
  logic [AW-1:0]         r_firstIdx;
  logic [LANES-1:0]      r_firstLanes;

  logic                  w_accept;
  logic                  w_startOk;
  logic [LANES-1:0]      w_laneMismatch;
  logic                  w_beatMismatch;

  assign w_accept  = (r_state == CHECK) && bus.dut_valid;
  assign w_startOk = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // Per-lane signed difference, one bit wider than a lane so it never overflows.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [BW:0] w_diff;
    logic        [BW:0] w_mag;
    assign w_diff = $signed({r_dut[g*BW + BW - 1], r_dut[g*BW +: BW]})
                  - $signed({bus.exp_data[g*BW + BW - 1], bus.exp_data[g*BW +: BW]});
    assign w_mag  = w_diff[BW] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_laneMismatch[g] = r_mode ? (w_mag > TOL_W) : (w_diff != '0);
  end

  assign w_beatMismatch = |w_laneMismatch;

  // Run-control FSM plus the compare stage; a start clears results last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_skip       <= '0;
      r_idx        <= '0;
      r_cmpValid   <= 1'b0;
      r_cmpIdx     <= '0;
      r_dut        <= '0;
      r_done       <= 1'b0;
      r_errCount   <= '0;
      r_firstValid <= 1'b0;
      r_firstIdx   <= '0;
      r_firstLanes <= '0;
    end else begin
      r_cmpValid <= w_accept;
      if (w_accept) begin
        r_dut    <= bus.dut_data;
        r_cmpIdx <= r_idx;
      end

      if (r_cmpValid && w_beatMismatch) begin
        if (r_errCount != 32'hFFFF_FFFF) begin
          r_errCount <= r_errCount + 32'd1;
        end
        if (!r_firstValid) begin
          r_firstValid <= 1'b1;
          r_firstIdx   <= r_cmpIdx;
          r_firstLanes <= w_laneMismatch;
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (w_startOk) begin
            r_mode       <= bus.mode;
            r_skip       <= bus.skip_beats;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_errCount   <= '0;
            r_firstValid <= 1'b0;
            r_firstIdx   <= '0;
            r_firstLanes <= '0;
            r_state      <= (bus.skip_beats != 16'd0) ? SKIP : CHECK;
          end
        end
        SKIP: begin
          if (bus.dut_valid) begin
            r_skip <= r_skip - 16'd1;
            if (r_skip == 16'd1) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (bus.dut_valid) begin
            if (r_idx == LAST_IDX) begin
              r_state <= DRAIN;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.exp_rd          = w_accept && !reset;
  assign bus.exp_addr        = r_idx;
  assign bus.busy            = (r_state == SKIP) || (r_state == CHECK) || (r_state == DRAIN);
  assign bus.done            = r_done;
  assign bus.pass            = r_done && (r_errCount == 32'd0);
  assign bus.err_count       = r_errCount;
  assign bus.first_err_valid = r_firstValid;
  assign bus.first_err_idx   = r_firstIdx;
  assign bus.first_err_lanes = r_firstLanes;

endmodule
